// File: rtl/nes_sprite_mixer_if.sv
// Bus bundle between OAM secondary evaluation / background fetch and the sprite mixer.
// The master drives loads and the pixel stream; the slave returns the mixed pixel.
interface nes_sprite_mixer_if #(
    parameter int unsigned SLOTS = 8
);
    localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic          ld;
    logic [SW-1:0] ld_slot;
    logic [7:0]    ld_x;
    logic [7:0]    ld_attr;
    logic [7:0]    ld_lo;
    logic [7:0]    ld_hi;
    logic          ld_clr;
    logic          line_start;
    logic          pix_en;
    logic [4:0]    bg;
    logic [7:0]    ctrl;
    logic          hit_clr;
    logic [4:0]    color;
    logic [7:0]    pix_x;
    logic          sprite0_hit;
    logic          overlap;

    modport master (
        output ld, ld_slot, ld_x, ld_attr, ld_lo, ld_hi, ld_clr,
        output line_start, pix_en, bg, ctrl, hit_clr,
        input  color, pix_x, sprite0_hit, overlap
    );

    modport slave (
        input  ld, ld_slot, ld_x, ld_attr, ld_lo, ld_hi, ld_clr,
        input  line_start, pix_en, bg, ctrl, hit_clr,
        output color, pix_x, sprite0_hit, overlap
    );
endinterface

// File: rtl/nes_sprite_mixer.sv
// Per-scanline NES sprite pixel engine: preloaded sprite slots are shifted out against the
// background stream, with slot priority, behind-background, left-column masking and sprite-0 hit.
module nes_sprite_mixer #(
    parameter int unsigned SLOTS  = 8,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    nes_sprite_mixer_if.slave bus
);
    localparam int unsigned SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [7:0]  LastPix = 8'(LINE_W - 1);

    typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} slot_st_e;

    // Per-slot storage; attr keeps {behind_bg, palette[1:0]}
    logic [7:0] x_q     [SLOTS];
    logic [2:0] attr_q  [SLOTS];
    logic       valid_q [SLOTS];
    logic [7:0] lo_q    [SLOTS];
    logic [7:0] lo_d    [SLOTS];
    logic [7:0] hi_q    [SLOTS];
    logic [7:0] hi_d    [SLOTS];
    logic [2:0] rem_q   [SLOTS];
    logic [2:0] rem_d   [SLOTS];
    slot_st_e   st_q    [SLOTS];
    slot_st_e   st_d    [SLOTS];

    logic [7:0] p_q;
    logic       run_q;
    logic [4:0] color_q, color_d;
    logic [7:0] pix_x_q;
    logic       hit_q;
    logic       ovl_q;

    logic             adv;
    logic             masked;
    logic [1:0]       pv [SLOTS];
    logic [SLOTS-1:0] opq;
    logic             win_found;
    logic [1:0]       win_pv;
    logic [2:0]       win_attr;
    logic             hit_set;
    logic             unused_bits;

    assign unused_bits = ^{bus.ld_attr[7], bus.ld_attr[4:2], bus.ctrl[7:5], bus.ctrl[3],
                           bus.ctrl[1:0]};

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    // run_q gates the pixel stream: off after reset until line_start, and off past the last pixel
    assign adv    = bus.pix_en && run_q && !bus.line_start;
    assign masked = !bus.ctrl[4] || (!bus.ctrl[2] && (p_q < 8'd8));

    // A waiting slot whose X matches already contributes its MSBs on this pixel
    always_comb begin
        opq = '0;
        for (int i = 0; i < SLOTS; i++) begin
            pv[i] = 2'b00;
            if (st_q[i] == StShift || (st_q[i] == StWait && p_q == x_q[i])) begin
                pv[i] = {hi_q[i][7], lo_q[i][7]};
            end
            opq[i] = (pv[i] != 2'b00);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_pv    = 2'b00;
        win_attr  = 3'b000;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (opq[i]) begin
                win_found = 1'b1;
                win_pv    = pv[i];
                win_attr  = attr_q[i];
            end
        end
    end

    // A behind-bg winner still hides higher slots, so bg shows through instead of them
    always_comb begin
        color_d = bus.bg;
        if (!masked && win_found && !(win_attr[2] && bus.bg[1:0] != 2'b00)) begin
            color_d = {1'b1, win_attr[1:0], win_pv};
        end
    end

    assign hit_set = adv && opq[0] && (bus.bg[1:0] != 2'b00) && (p_q != 8'd255) && !masked;

    // Slot FSM next state, shifters and pattern loads
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            st_d[i]  = st_q[i];
            lo_d[i]  = lo_q[i];
            hi_d[i]  = hi_q[i];
            rem_d[i] = rem_q[i];
            if (bus.line_start) begin
                st_d[i] = valid_q[i] ? StWait : StIdle;
            end else if (adv) begin
                unique case (st_q[i])
                    StWait: begin
                        // Entry pixel consumes bit 7, leaving 7 more: rem counts 6..0
                        if (p_q == x_q[i]) begin
                            st_d[i]  = StShift;
                            lo_d[i]  = {lo_q[i][6:0], 1'b0};
                            hi_d[i]  = {hi_q[i][6:0], 1'b0};
                            rem_d[i] = 3'd6;
                        end
                    end
                    StShift: begin
                        lo_d[i]  = {lo_q[i][6:0], 1'b0};
                        hi_d[i]  = {hi_q[i][6:0], 1'b0};
                        rem_d[i] = rem_q[i] - 3'd1;
                        if (rem_q[i] == 3'd0) st_d[i] = StDone;
                    end
                    default: ;
                endcase
            end
            if (bus.ld && !bus.ld_clr && bus.ld_slot == SW'(i)) begin
                lo_d[i] = bus.ld_attr[6] ? rev8(bus.ld_lo) : bus.ld_lo;
                hi_d[i] = bus.ld_attr[6] ? rev8(bus.ld_hi) : bus.ld_hi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]  <= StIdle;
                lo_q[i]  <= 8'h00;
                hi_q[i]  <= 8'h00;
                rem_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]  <= st_d[i];
                lo_q[i]  <= lo_d[i];
                hi_q[i]  <= hi_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= 8'h00;
                attr_q[i]  <= 3'b000;
            end
        end else if (bus.ld_clr) begin
            for (int i = 0; i < SLOTS; i++) valid_q[i] <= 1'b0;
        end else if (bus.ld) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (bus.ld_slot == SW'(i)) begin
                    valid_q[i] <= 1'b1;
                    x_q[i]     <= bus.ld_x;
                    attr_q[i]  <= {bus.ld_attr[5], bus.ld_attr[1:0]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= 8'h00;
            run_q   <= 1'b0;
            color_q <= 5'h00;
            pix_x_q <= 8'h00;
            ovl_q   <= 1'b0;
        end else if (bus.line_start) begin
            p_q   <= 8'h00;
            run_q <= 1'b1;
        end else if (adv) begin
            color_q <= color_d;
            pix_x_q <= p_q;
            ovl_q   <= ($countones(opq) > 1);
            if (p_q == LastPix) run_q <= 1'b0;
            else                p_q   <= p_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           hit_q <= 1'b0;
        else if (bus.hit_clr) hit_q <= 1'b0;
        else if (hit_set)     hit_q <= 1'b1;
    end

    assign bus.color       = color_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.sprite0_hit = hit_q;
    assign bus.overlap     = ovl_q;
endmodule
